fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller driving the 256-byte big-endian instruction ROM (8-bit byte address in, 32-bit word out, combinational read).
- Holds PA-RISC-style front/back program counters (PC, nPC) with one architectural delay slot.
- Applies stall, flush, branch-redirect and halt.
- Registers the fetched word into the IF/ID pipeline register for the decode stage.

Parameters:
- ADDR_W, 8, ROM byte-address width; PC arithmetic is modulo 2^ADDR_W.
- INSTR_W, 32, instruction width.
- RESET_PC, 8'h00, PC value loaded at reset.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_address  out  ADDR_W  byte address to ROM; equals current PC register, combinational from flops only.
- rom_instruction  in  INSTR_W  ROM word read at rom_address.
- stall  in  1  hold PC, nPC and IF/ID contents.
- flush  in  1  replace the IF/ID contents with NOP next edge.
- branch_taken  in  1  redirect request from the execute stage.
- branch_target  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- halt_req  in  1  stop fetching permanently until reset.
- if_id_instr  out  INSTR_W  registered instruction to decode.
- if_id_pc  out  ADDR_W  registered PC of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real fetch, not a bubble.
- halted  out  1  high in HALTED state.
- fetch_count  out  CNT_W  number of valid words loaded into IF/ID; wraps at 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC=RESET_PC; nPC=RESET_PC+4.
  - if_id_instr=NOP (32'h08000240); if_id_pc=0; if_id_valid=0.
  - halted=0; fetch_count=0; state=BOOT.
- FSM states: BOOT, RUN, HALTED.
- BOOT: one cycle after reset release.
  - No PC update; IF/ID stays NOP, valid=0.
  - Next state RUN unconditionally, or HALTED if halt_req=1.
- RUN, per rising edge, in priority order:
  1. halt_req=1 -> state HALTED. PC/nPC hold. IF/ID loads NOP, valid=0.
  2. stall=1 -> PC, nPC, IF/ID all hold.
     - A branch_taken asserted in the same cycle is ignored; the requester must hold it until stall drops.
     - If flush=1 together with stall, IF/ID loads NOP with valid=0 (flush overrides hold); PC/nPC still hold.
  3. Otherwise:
     - PC <= nPC.
     - nPC <= branch_taken ? {branch_target[7:2],2'b00} : nPC+4.
     - IF/ID <= flush ? {NOP, PC, 0} : {rom_instruction, PC, 1}.
     - fetch_count increments only when the loaded valid bit is 1.
- Delay slot: the instruction at the old nPC is always fetched after a taken branch. The target is fetched one cycle later.
- Wrap-around: nPC+4 from 8'hFC yields 8'h00; no flag, no stall.
- HALTED: absorbing state until reset.
  - PC/nPC frozen; IF/ID holds NOP with valid=0.
  - halted=1; all other inputs ignored.
- Latency: a word appears on if_id_instr one edge after its address is on rom_address.
- Reset mid-operation: all state returns to reset values immediately, with no waiting for a clock edge.
- rom_address is never X after reset, and the block never reads the address from an input combinationally.

Decomposition:
- Shared package fetch_pkg holds:
  - localparam NOP_INSTR = 32'h08000240.
  - ADDR_W / INSTR_W defaults.
  - typedef for the FSM state enum {BOOT, RUN, HALTED}.
  - packed struct if_id_t {instr, pc, valid} reused by the decode stage.
- One natural sub-module: pc_queue, holding the PC/nPC registers, the next-PC mux and the +4 adder with hold/redirect inputs. The FSM, IF/ID register and counter stay in the top.

Test Plan:
- Reset then free-run, ROM word at byte address n = 32'h1000_0000+n: rom_address sequence 00, 04, 08, 0C, ... beginning the edge after BOOT; if_id_instr = 32'h1000_0000, 1000_0004, ... one cycle later; fetch_count = 3 after three valid loads.
- Taken branch at PC=08 (nPC=0C), branch_target=8'h43: fetch order 08, 0C (delay slot), 40, 44; if_id_pc follows the same order.
- stall=1 for 2 cycles at PC=10 with branch_taken=1 in the first stall cycle: PC stays 10 and IF/ID unchanged for both cycles; the branch is ignored; fetch resumes at 14; fetch_count is not incremented during the stall.
- flush=1 with stall=0 at PC=20: IF/ID = {08000240, 20, 0}; the next edge loads the word at 24 as valid; fetch_count skips the flushed slot.
- Wrap-around: run from PC=F8: addresses F8, FC, 00, 04, with no bubble.
- halt_req at PC=30, then rst_n pulsed low mid-cycle: halted=1 and rom_address frozen at 30 until reset; on the asynchronous reset assertion, halted=0, rom_address=00, if_id_valid=0 and fetch_count=0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch front end and the decode stage.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0800_0240;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_e;

  // IF/ID pipeline register contents, also consumed by decode.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
    logic                   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM bus, pipeline control inputs and IF/ID outputs of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_instruction;
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt_req;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  // The fetch sequencer side.
  modport master (
    output rom_address, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
    input  rom_instruction, stall, flush, branch_taken, branch_target, halt_req
  );

  // The ROM / pipeline environment side.
  modport slave (
    input  rom_address, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
    output rom_instruction, stall, flush, branch_taken, branch_target, halt_req
  );
endinterface

// File: rtl/fetch_sequencer_pc_queue.sv
// Front/back program counter pair with one delay slot: PC takes nPC, nPC takes
// either the word-aligned redirect target or nPC+4 (wrapping modulo 2^ADDR_W).
module pc_queue #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;

  // Next-PC mux; the low two target bits are dropped to keep fetches word aligned.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (advance_i) begin
      pc_d  = npc_q;
      npc_d = redirect_i ? (target_i & ~ADDR_W'(3)) : (npc_q + ADDR_W'(4));
    end
  end

  // PC/nPC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + ADDR_W'(4);
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc_o  = pc_q;
  assign npc_o = npc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences PC/nPC, applies halt/stall/flush/branch,
// and registers the fetched ROM word into IF/ID.
module fetch_sequencer #(
  parameter int                ADDR_W   = fetch_pkg::DEF_ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);
  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  if_id_t             ifid_q, ifid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               advance;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  npc;
  logic [INSTR_W-1:0] rom_word;

  assign rom_word = bus.rom_instruction;

  pc_queue #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance_i  (advance),
    .redirect_i (bus.branch_taken),
    .target_i   (bus.branch_target),
    .pc_o       (pc),
    .npc_o      (npc)
  );

  // Next state, IF/ID load and counter update; halt beats stall beats normal fetch.
  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = bus.halt_req ? HALTED : RUN;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d      = HALTED;
          ifid_d.instr = NOP_INSTR;
          ifid_d.valid = 1'b0;
        end else if (bus.stall) begin
          if (bus.flush) begin
            ifid_d = '{instr: NOP_INSTR, pc: pc, valid: 1'b0};
          end
        end else begin
          advance = 1'b1;
          if (bus.flush) begin
            ifid_d = '{instr: NOP_INSTR, pc: pc, valid: 1'b0};
          end else begin
            ifid_d = '{instr: rom_word, pc: pc, valid: 1'b1};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, IF/ID and retired-fetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      ifid_q  <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rom_address = pc;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_pc    = ifid_q.pc;
  assign bus.if_id_valid = ifid_q.valid;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = cnt_q;

  logic unused_npc;
  assign unused_npc = ^npc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a cycle-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0800_0240;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic run_chk = 1'b0;

  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(32), .CNT_W(16)) bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM: word at byte address n is 32'h1000_0000 + n.
  assign bus.rom_instruction = 32'h1000_0000 + {24'h0, bus.rom_address};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [7:0]  m_pc, m_npc, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_pc    <= 8'h00;
      m_npc   <= 8'h04;
      m_ipc   <= 8'h00;
      m_instr <= NOP;
      m_valid <= 1'b0;
      m_cnt   <= 16'd0;
    end else if (m_mode == 0) begin
      m_mode <= bus.halt_req ? 2 : 1;
    end else if (m_mode == 1) begin
      if (bus.halt_req) begin
        m_mode  <= 2;
        m_instr <= NOP;
        m_valid <= 1'b0;
      end else if (bus.stall) begin
        if (bus.flush) begin
          m_instr <= NOP;
          m_valid <= 1'b0;
          m_ipc   <= m_pc;
        end
      end else begin
        m_pc  <= m_npc;
        m_npc <= bus.branch_taken ? (bus.branch_target & 8'hFC) : m_npc + 8'd4;
        m_ipc <= m_pc;
        if (bus.flush) begin
          m_instr <= NOP;
          m_valid <= 1'b0;
        end else begin
          m_instr <= 32'h1000_0000 + {24'h0, m_pc};
          m_valid <= 1'b1;
          m_cnt   <= m_cnt + 16'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk("m_rom_address", {24'h0, bus.rom_address}, {24'h0, m_pc});
      chk("m_if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, m_valid});
      chk("m_if_id_instr", bus.if_id_instr, m_instr);
      if (m_valid) chk("m_if_id_pc", {24'h0, bus.if_id_pc}, {24'h0, m_ipc});
      chk("m_halted", {31'h0, bus.halted}, 32'(m_mode == 2));
      chk("m_fetch_count", {16'h0, bus.fetch_count}, {16'h0, m_cnt});
    end
  end

  task automatic branch_to(input logic [7:0] tgt);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    @(negedge clk);
    bus.branch_taken  = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    bus.halt_req      = 1'b0;
    #12;
    chk("rst_addr",  {24'h0, bus.rom_address}, 32'h00);
    chk("rst_instr", bus.if_id_instr, NOP);
    chk("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("rst_count", {16'h0, bus.fetch_count}, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    run_chk = 1'b1;

    // Free run from reset.
    @(negedge clk);
    chk("boot_addr",  {24'h0, bus.rom_address}, 32'h00);
    chk("boot_valid", {31'h0, bus.if_id_valid}, 32'h0);
    @(negedge clk);
    chk("first_addr",  {24'h0, bus.rom_address}, 32'h04);
    chk("first_instr", bus.if_id_instr, 32'h1000_0000);
    @(negedge clk);
    chk("second_instr", bus.if_id_instr, 32'h1000_0004);

    // Taken branch at PC=08 to 43 (aligned 40), delay slot 0C.
    branch_to(8'h43);
    chk("count3",      {16'h0, bus.fetch_count}, 32'd3);
    chk("slot_addr",   {24'h0, bus.rom_address}, 32'h0C);
    chk("br_ifid_pc",  {24'h0, bus.if_id_pc}, 32'h08);
    @(negedge clk);
    chk("target_addr", {24'h0, bus.rom_address}, 32'h40);
    chk("slot_ifid",   {24'h0, bus.if_id_pc}, 32'h0C);
    @(negedge clk);
    chk("tgt_ifid",    {24'h0, bus.if_id_pc}, 32'h40);
    @(negedge clk);
    chk("tgt4_ifid",   {24'h0, bus.if_id_pc}, 32'h44);

    // Stall two cycles at PC=10 with an ignored branch.
    branch_to(8'h10);
    @(negedge clk);
    chk("stall_pc0",  {24'h0, bus.rom_address}, 32'h10);
    chk("stall_cnt0", {16'h0, bus.fetch_count}, 32'd8);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h80;
    @(negedge clk);
    bus.branch_taken  = 1'b0;
    @(negedge clk);
    chk("stall_pc2",   {24'h0, bus.rom_address}, 32'h10);
    chk("stall_ifid",  {24'h0, bus.if_id_pc}, 32'h4C);
    chk("stall_cnt2",  {16'h0, bus.fetch_count}, 32'd8);
    bus.stall = 1'b0;
    @(negedge clk);
    chk("resume_addr", {24'h0, bus.rom_address}, 32'h14);
    chk("resume_ifid", {24'h0, bus.if_id_pc}, 32'h10);
    chk("resume_cnt",  {16'h0, bus.fetch_count}, 32'd9);

    // Flush at PC=20.
    branch_to(8'h20);
    @(negedge clk);
    chk("flush_at", {24'h0, bus.rom_address}, 32'h20);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_instr", bus.if_id_instr, NOP);
    chk("flush_pc",    {24'h0, bus.if_id_pc}, 32'h20);
    chk("flush_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("flush_cnt",   {16'h0, bus.fetch_count}, 32'd11);
    @(negedge clk);
    chk("post_flush_pc",  {24'h0, bus.if_id_pc}, 32'h24);
    chk("post_flush_val", {31'h0, bus.if_id_valid}, 32'h1);
    chk("post_flush_cnt", {16'h0, bus.fetch_count}, 32'd12);

    // Wrap-around from F8.
    branch_to(8'hF8);
    @(negedge clk);
    chk("wrap_f8", {24'h0, bus.rom_address}, 32'hF8);
    @(negedge clk);
    chk("wrap_fc", {24'h0, bus.rom_address}, 32'hFC);
    @(negedge clk);
    chk("wrap_00", {24'h0, bus.rom_address}, 32'h00);
    @(negedge clk);
    chk("wrap_04",    {24'h0, bus.rom_address}, 32'h04);
    chk("wrap_ifid",  {24'h0, bus.if_id_pc}, 32'h00);
    chk("wrap_valid", {31'h0, bus.if_id_valid}, 32'h1);

    // Halt at PC=30, then asynchronous reset mid-cycle.
    branch_to(8'h30);
    @(negedge clk);
    chk("halt_at", {24'h0, bus.rom_address}, 32'h30);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req     = 1'b0;
    chk("halted",      {31'h0, bus.halted}, 32'h1);
    chk("halt_addr",   {24'h0, bus.rom_address}, 32'h30);
    chk("halt_valid",  {31'h0, bus.if_id_valid}, 32'h0);
    bus.stall        = 1'b1;
    bus.flush        = 1'b1;
    bus.branch_taken = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_hold",   {24'h0, bus.rom_address}, 32'h30);
    chk("halt_sticky", {31'h0, bus.halted}, 32'h1);
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted", {31'h0, bus.halted}, 32'h0);
    chk("arst_addr",   {24'h0, bus.rom_address}, 32'h00);
    chk("arst_valid",  {31'h0, bus.if_id_valid}, 32'h0);
    chk("arst_count",  {16'h0, bus.fetch_count}, 32'h0);

    // Restart, then stall together with flush.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("re_addr", {24'h0, bus.rom_address}, 32'h08);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    chk("sf_addr",  {24'h0, bus.rom_address}, 32'h08);
    chk("sf_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("sf_cnt",   {16'h0, bus.fetch_count}, 32'd2);
    repeat (2) @(negedge clk);
    chk("sf_resume", {24'h0, bus.rom_address}, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
